// File: rtl/truth_table_scanner_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg
//   Shared definitions for the truth-table scanner: the scan FSM state
//   encoding, default geometry of the candidate circuit, the default table
//   width and helper functions that size the table and the mismatch counter.
//   No ports; imported by the interface, the top module and the settle timer.
// ---------------------------------------------------------------------------
package tt_pkg;

    // Scan FSM states. The ST_ prefix keeps the settle state apart from the
    // SETTLE parameter that every scanner instance carries.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

    // Default candidate geometry: four inputs (A..D), one output (Y0), and
    // two extra hold cycles per vector before the output is sampled.
    localparam int N_IN_DEFAULT   = 4;
    localparam int N_OUT_DEFAULT  = 1;
    localparam int SETTLE_DEFAULT = 2;

    // Number of bits in a full truth table for the default geometry.
    localparam int TT_W = (2 ** N_IN_DEFAULT) * N_OUT_DEFAULT;

    // Bits in a truth table: one entry of n_out bits for each of 2**n_in vectors.
    function automatic int tt_table_width(input int n_in, input int n_out);
        return (1 << n_in) * n_out;
    endfunction

    // The mismatch counter must hold every value from 0 up to the full table
    // width, so it never has to saturate explicitly.
    function automatic int tt_err_width(input int table_w);
        return $clog2(table_w + 1);
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_if
//   Bundles the scan request, the candidate-circuit connection and the
//   results of the truth-table scanner into one interface.
//
//   Signals
//     start     request a scan (only honoured while the scanner is idle)
//     target    expected table; bit v*N_OUT+j is output j for vector v
//     vec_out   vector currently applied to the candidate inputs
//     y_in      candidate outputs returned to the scanner
//     busy      scan in progress
//     done      one-cycle completion pulse
//     response  measured table, same layout as target
//     errors    number of bits where response differs from target
//
//   Modports
//     master  the requester / test environment side
//     slave   the scanner itself
// ---------------------------------------------------------------------------
interface truth_table_scanner_if
    import tt_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int N_OUT = N_OUT_DEFAULT
);

    localparam int TBL_W = tt_table_width(N_IN, N_OUT);
    localparam int ERR_W = tt_err_width(TBL_W);

    logic              start;
    logic [TBL_W-1:0]  target;
    logic [N_IN-1:0]   vec_out;
    logic [N_OUT-1:0]  y_in;
    logic              busy;
    logic              done;
    logic [TBL_W-1:0]  response;
    logic [ERR_W-1:0]  errors;

    modport master (
        output start,
        output target,
        output y_in,
        input  vec_out,
        input  busy,
        input  done,
        input  response,
        input  errors
    );

    modport slave (
        input  start,
        input  target,
        input  y_in,
        output vec_out,
        output busy,
        output done,
        output response,
        output errors
    );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
//   Counts the hold time of one applied vector. A load pulse (given in the
//   cycle before a new vector appears) reloads the counter with SETTLE; the
//   counter then walks down to zero and stays there.
//
//   Ports
//     clk          clock, everything on posedge
//     rst          synchronous active-high reset
//     load         restart the hold time for the next vector
//     expire       high in the final hold cycle of the current vector
//     expire_next  high in the cycle just before the final hold cycle
// ---------------------------------------------------------------------------
module settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire,
    output logic expire_next
);

    // A zero settle time still needs a one-bit counter to keep the logic legal.
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE);

    logic [CW-1:0] count;

    // Reload on a vector change, otherwise count down and park at zero so the
    // expire flag stays meaningful even if the scanner lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire      = (count == '0);
    assign expire_next = (count == CW'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
//   Walks every input vector of a combinational candidate circuit, holds each
//   vector for SETTLE+1 cycles, samples the candidate outputs in the last of
//   those cycles and assembles the measured truth table. Every sampled entry
//   is compared with a target table latched at start, and the total number
//   of differing bits is reported as the fitness value.
//
//   Parameters
//     N_IN    candidate inputs; the scan covers 2**N_IN vectors
//     N_OUT   candidate outputs
//     SETTLE  extra hold cycles before sampling (0 allowed)
//
//   Ports
//     clk   clock, everything on posedge
//     rst   synchronous active-high reset, overrides everything
//     bus   slave side of truth_table_scanner_if:
//             start/target in, vec_out to the candidate, y_in from the
//             candidate, busy/done status, response/errors results
// ---------------------------------------------------------------------------
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int N_OUT  = N_OUT_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus
);

    localparam int TBL_W = tt_table_width(N_IN, N_OUT);
    localparam int ERR_W = tt_err_width(TBL_W);
    localparam int N_VEC = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    // With no extra settle cycles a fresh vector is sampled in its first cycle.
    localparam tt_state_t HOLD_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    tt_state_t         state;
    tt_state_t         next_state;

    logic [N_IN-1:0]   vec_cnt;
    logic [TBL_W-1:0]  target_lat;
    logic [TBL_W-1:0]  response_q;
    logic [ERR_W-1:0]  errors_q;

    logic              accept;
    logic              last_vec;
    logic              sample_en;
    logic              timer_load;
    logic              timer_expire;
    logic              timer_expire_next;

    logic [TBL_W-1:0]  resp_next;
    logic [N_OUT-1:0]  mismatch;
    logic [ERR_W-1:0]  err_inc;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (timer_load),
        .expire      (timer_expire),
        .expire_next (timer_expire_next)
    );

    // The vector counter terminates explicitly on the last vector, so it
    // never wraps back into a second pass.
    assign accept     = (state == ST_IDLE) && bus.start;
    assign last_vec   = (vec_cnt == LAST_VEC);
    assign sample_en  = (state == ST_SAMPLE) && timer_expire;

    // The timer is reloaded whenever a new vector is about to be driven:
    // on an accepted start (vector 0) and after each non-final sample.
    assign timer_load = accept || ((state == ST_SAMPLE) && !last_vec);

    // State register; reset returns straight to idle, dropping any scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Start is only looked at in idle, so a start seen
    // while scanning or in the done cycle is simply dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state = HOLD_ENTRY;
                end
            end
            ST_SETTLE: begin
                if (timer_expire_next) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_vec) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = HOLD_ENTRY;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Merge the sampled outputs into the table slot of the current vector and
    // count how many of them disagree with the latched target slot.
    always_comb begin
        resp_next = response_q;
        mismatch  = '0;
        for (int v = 0; v < N_VEC; v++) begin
            if (vec_cnt == N_IN'(v)) begin
                resp_next[v*N_OUT +: N_OUT] = bus.y_in;
                mismatch = bus.y_in ^ target_lat[v*N_OUT +: N_OUT];
            end
        end
        err_inc = '0;
        for (int j = 0; j < N_OUT; j++) begin
            err_inc = err_inc + ERR_W'(mismatch[j]);
        end
    end

    // Scan datapath. An accepted start snapshots the target and clears the
    // previous results; otherwise results hold until the next accepted start.
    // After the final sample the counter returns to zero so the candidate
    // sees vector 0 while the scanner is done or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt    <= '0;
            target_lat <= '0;
            response_q <= '0;
            errors_q   <= '0;
        end else if (accept) begin
            vec_cnt    <= '0;
            target_lat <= bus.target;
            response_q <= '0;
            errors_q   <= '0;
        end else if (sample_en) begin
            response_q <= resp_next;
            errors_q   <= errors_q + err_inc;
            vec_cnt    <= last_vec ? '0 : vec_cnt + N_IN'(1);
        end
    end

    assign bus.vec_out  = vec_cnt;
    assign bus.busy     = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.response = response_q;
    assign bus.errors   = errors_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
//   Drives two scanner instances: a 4-input/1-output scanner with two settle
//   cycles, whose candidate only shows its true output once a vector has been
//   held long enough, and a 4-input/2-output scanner with no settle cycles
//   wired to y = {A^B, C|D}. Expected tables come from the candidate
//   functions evaluated over all vectors.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;
    import tt_pkg::*;

    localparam int SETTLE_A = 2;
    localparam int LAT_A    = 1 + 16 * (SETTLE_A + 1);
    localparam int LAT_B    = 1 + 16;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(4), .N_OUT(1)) bus_a ();
    truth_table_scanner_if #(.N_IN(4), .N_OUT(2)) bus_b ();

    truth_table_scanner #(.N_IN(4), .N_OUT(1), .SETTLE(SETTLE_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    truth_table_scanner #(.N_IN(4), .N_OUT(2), .SETTLE(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Candidate A: 0 -> Y0=D, 1 -> Y0=A&B&C&D, other -> lookup table.
    int              cand_sel = 0;
    logic [TT_W-1:0] cand_tbl = '0;

    function automatic logic cand_a_fn(input int sel, input logic [3:0] v,
                                       input logic [15:0] tbl);
        case (sel)
            0:       return v[0];
            1:       return v[3] & v[2] & v[1] & v[0];
            default: return tbl[v];
        endcase
    endfunction

    // Expected table of candidate A over all 16 vectors.
    function automatic logic [15:0] ref_resp_a(input int sel, input logic [15:0] tbl);
        logic [15:0] r;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            r[v] = cand_a_fn(sel, 4'(v), tbl);
        end
        return r;
    endfunction

    // Expected table of candidate B: bit v*2+1 = A^B, bit v*2 = C|D.
    function automatic logic [31:0] ref_resp_b();
        logic [31:0] r;
        logic [3:0]  vv;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            r[v*2+1] = vv[3] ^ vv[2];
            r[v*2]   = vv[1] | vv[0];
        end
        return r;
    endfunction

    // Candidate A settles slowly: until the same vector has been visible for
    // SETTLE_A full cycles its output is the complement of the true value.
    int         age_a       = 0;
    logic [3:0] last_vec_a  = '0;
    logic       last_busy_a = 1'b0;

    always @(negedge clk) begin
        if (!last_busy_a || (bus_a.vec_out != last_vec_a)) begin
            age_a <= 0;
        end else begin
            age_a <= age_a + 1;
        end
        last_vec_a  <= bus_a.vec_out;
        last_busy_a <= bus_a.busy;
    end

    assign bus_a.y_in = (age_a >= SETTLE_A) ? cand_a_fn(cand_sel, bus_a.vec_out, cand_tbl)
                                            : ~cand_a_fn(cand_sel, bus_a.vec_out, cand_tbl);

    assign bus_b.y_in = {bus_b.vec_out[3] ^ bus_b.vec_out[2],
                         bus_b.vec_out[1] | bus_b.vec_out[0]};

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs from the first cycle of a scan on A until done, or until the cycle
    // budget runs out. Counts cycles whose busy/vec_out differ from the
    // expected staircase of each vector held SETTLE_A+1 cycles. Optionally
    // flips the target at a given cycle to prove it was latched.
    task automatic waitDoneA(input int toggle_at, output int cyc, output int bad);
        cyc = 1;
        bad = 0;
        while (bus_a.done !== 1'b1 && cyc < 200) begin
            if (bus_a.busy !== 1'b1 || bus_a.vec_out !== 4'((cyc - 1) / (SETTLE_A + 1)))
                bad++;
            if (cyc == toggle_at)
                bus_a.target = ~bus_a.target;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One full scan on A from an idle cycle, with checks in the done cycle
    // and in the idle cycle that follows it.
    task automatic applyStimulus(input string tag, input logic [15:0] tgt,
                                 input int sel, input logic [15:0] tbl, input bit hold,
                                 input logic [15:0] exp_resp, input int exp_err);
        int cyc;
        int bad;
        bus_a.target = tgt;
        cand_sel     = sel;
        cand_tbl     = tbl;
        bus_a.start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold)
            bus_a.start = 1'b0;
        waitDoneA(hold ? 20 : 0, cyc, bad);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(LAT_A));
        checkOutput({tag, "_vec_seq"}, 64'(bad), 64'd0);
        checkOutput({tag, "_busy_in_done"}, 64'(bus_a.busy), 64'd0);
        checkOutput({tag, "_response"}, 64'(bus_a.response), 64'(exp_resp));
        checkOutput({tag, "_errors"}, 64'(bus_a.errors), 64'(exp_err));
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_done"}, 64'(bus_a.done), 64'd0);
        checkOutput({tag, "_idle_busy"}, 64'(bus_a.busy), 64'd0);
        checkOutput({tag, "_idle_vec"}, 64'(bus_a.vec_out), 64'd0);
        checkOutput({tag, "_hold_resp"}, 64'(bus_a.response), 64'(exp_resp));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        int          bad;
        logic [15:0] rt;
        logic [15:0] rtbl;
        logic [15:0] rexp;
        logic [31:0] tb_exp;
        logic [31:0] tb_tgts [3];

        rst          = 1'b1;
        bus_a.start  = 1'b0;
        bus_a.target = '0;
        bus_b.start  = 1'b0;
        bus_b.target = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vec", 64'(bus_a.vec_out), 64'd0);
        checkOutput("rst_busy", 64'(bus_a.busy), 64'd0);
        checkOutput("rst_done", 64'(bus_a.done), 64'd0);
        checkOutput("rst_resp", 64'(bus_a.response), 64'd0);
        checkOutput("rst_errors", 64'(bus_a.errors), 64'd0);
        checkOutput("rst_b_busy", 64'(bus_b.busy), 64'd0);
        checkOutput("rst_b_errors", 64'(bus_b.errors), 64'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Y0=D against matching, inverted and AND-4 targets
        applyStimulus("t1_match", 16'hAAAA, 0, 16'h0, 1'b0, 16'hAAAA, 0);
        applyStimulus("t2_invert", 16'h5555, 0, 16'h0, 1'b0, 16'hAAAA, 16);
        applyStimulus("t3_and4", 16'h0000, 1, 16'h0, 1'b0, 16'h8000, 1);

        // Reset in the middle of a scan
        bus_a.target = 16'h1234;
        cand_sel     = 0;
        bus_a.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        cyc = 0;
        while (bus_a.vec_out !== 4'd7 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("t4_reach_vec7", 64'(bus_a.vec_out), 64'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4_rst_busy", 64'(bus_a.busy), 64'd0);
        checkOutput("t4_rst_vec", 64'(bus_a.vec_out), 64'd0);
        checkOutput("t4_rst_errors", 64'(bus_a.errors), 64'd0);
        checkOutput("t4_rst_resp", 64'(bus_a.response), 64'd0);
        checkOutput("t4_rst_done", 64'(bus_a.done), 64'd0);
        rst = 1'b0;
        applyStimulus("t4_rescan", 16'h0F0F, 0, 16'h0, 1'b0, 16'hAAAA,
                      $countones(16'hAAAA ^ 16'h0F0F));

        // Start held through the scan, target flipped mid-scan, back-to-back
        applyStimulus("t5_hold", 16'hAAA0, 0, 16'h0, 1'b1, 16'hAAAA, 2);
        @(posedge clk);
        #1;
        checkOutput("t5_second_busy", 64'(bus_a.busy), 64'd1);
        bus_a.start = 1'b0;
        waitDoneA(0, cyc, bad);
        checkOutput("t5_second_latency", 64'(cyc), 64'(LAT_A));
        checkOutput("t5_second_vec_seq", 64'(bad), 64'd0);
        checkOutput("t5_second_resp", 64'(bus_a.response), 64'hAAAA);
        checkOutput("t5_second_errors", 64'(bus_a.errors),
                    64'($countones(16'hAAAA ^ 16'h555F)));
        @(posedge clk);
        #1;

        // Random candidate tables and targets
        for (int i = 0; i < 3; i++) begin
            rt   = 16'($urandom);
            rtbl = 16'($urandom);
            rexp = ref_resp_a(2, rtbl);
            applyStimulus("rand_a", rt, 2, rtbl, 1'b0, rexp, $countones(rexp ^ rt));
        end

        // Two-output candidate with no settle cycles
        tb_exp     = ref_resp_b();
        tb_tgts[0] = $urandom;
        tb_tgts[1] = 32'h0000_0000;
        tb_tgts[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bus_b.target = tb_tgts[i];
            bus_b.start  = 1'b1;
            @(posedge clk);
            #1;
            bus_b.start = 1'b0;
            cyc = 1;
            bad = 0;
            while (bus_b.done !== 1'b1 && cyc < 200) begin
                if (bus_b.busy !== 1'b1 || bus_b.vec_out !== 4'(cyc - 1))
                    bad++;
                @(posedge clk);
                #1;
                cyc++;
            end
            checkOutput("t6_latency", 64'(cyc), 64'(LAT_B));
            checkOutput("t6_vec_seq", 64'(bad), 64'd0);
            checkOutput("t6_response", 64'(bus_b.response), 64'(tb_exp));
            checkOutput("t6_errors", 64'(bus_b.errors), 64'($countones(tb_exp ^ tb_tgts[i])));
            @(posedge clk);
            #1;
            checkOutput("t6_idle_done", 64'(bus_b.done), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
